// File: rtl/pc_next_if.sv
// Request and status bundle between the pipeline control and the PC stage.
interface pc_next_if #(
    parameter int W = 32
);
    logic         stall_i;
    logic         exc_i;
    logic         jmp_i;
    logic [W-1:0] jmp_target_i;
    logic         br_i;
    logic [W-1:0] br_target_i;
    logic [W-1:0] pc_o;
    logic [W-1:0] pc_plus_o;
    logic         redirect_o;
    logic         pend_o;

    modport master (
        output stall_i, exc_i, jmp_i, jmp_target_i, br_i, br_target_i,
        input  pc_o, pc_plus_o, redirect_o, pend_o
    );

    modport slave (
        input  stall_i, exc_i, jmp_i, jmp_target_i, br_i, br_target_i,
        output pc_o, pc_plus_o, redirect_o, pend_o
    );
endinterface

// File: rtl/pc_next_unit.sv
// Program-counter stage: picks the next PC from exception / jump / branch /
// sequential sources by fixed priority, holds on stall, and remembers a
// redirect that arrives during a stall so it is applied on release.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal flow; no redirect waiting
//   PEND  | stalled with a latched redirect waiting for stall release
module pc_next_unit #(
    parameter int           W        = 32,
    parameter logic [W-1:0] RESET_PC = '0,
    parameter logic [W-1:0] EXC_VEC  = W'(32'h80),
    parameter int           INC      = 4,
    parameter int           ALIGN    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_next_if.slave      bus
);
    // Clears the low ALIGN bits of every redirect target; all-ones when ALIGN=0.
    localparam logic [W-1:0] ALIGN_MASK = ~((W'(1) << ALIGN) - W'(1));

    // Kind codes double as priority: a larger code beats a smaller one.
    typedef enum logic [1:0] {
        K_NONE = 2'd0,
        K_BR   = 2'd1,
        K_JMP  = 2'd2,
        K_EXC  = 2'd3
    } kind_t;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_PEND = 1'b1
    } state_t;

    state_t       r_state;
    logic [W-1:0] r_pc;
    logic         r_redirect;
    logic         r_pend;
    kind_t        r_pend_kind;
    logic [W-1:0] r_pend_addr;

    kind_t        w_req_kind;
    logic [W-1:0] w_req_addr;
    logic [W-1:0] w_pc_plus;

    assign w_pc_plus = r_pc + W'(INC);

    // Highest-priority request this cycle, with its aligned target.
    always_comb begin
        w_req_kind = K_NONE;
        w_req_addr = '0;
        if (bus.exc_i) begin
            w_req_kind = K_EXC;
            w_req_addr = EXC_VEC & ALIGN_MASK;
        end else if (bus.jmp_i) begin
            w_req_kind = K_JMP;
            w_req_addr = bus.jmp_target_i & ALIGN_MASK;
        end else if (bus.br_i) begin
            w_req_kind = K_BR;
            w_req_addr = bus.br_target_i & ALIGN_MASK;
        end
    end

    // PC register, redirect/pending flags and the stall-time redirect latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_pc        <= RESET_PC;
            r_redirect  <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_kind <= K_NONE;
            r_pend_addr <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!bus.stall_i) begin
                        if (w_req_kind != K_NONE) begin
                            r_pc       <= w_req_addr;
                            r_redirect <= 1'b1;
                        end else begin
                            r_pc       <= w_pc_plus;
                            r_redirect <= 1'b0;
                        end
                    end else begin
                        r_redirect <= 1'b0;
                        if (w_req_kind != K_NONE) begin
                            r_pend_addr <= w_req_addr;
                            r_pend_kind <= w_req_kind;
                            r_pend      <= 1'b1;
                            r_state     <= S_PEND;
                        end
                    end
                end
                S_PEND: begin
                    if (bus.stall_i) begin
                        r_redirect <= 1'b0;
                        // Latched kind is never NONE here, so >= implies a real request.
                        if (w_req_kind >= r_pend_kind) begin
                            r_pend_addr <= w_req_addr;
                            r_pend_kind <= w_req_kind;
                        end
                    end else begin
                        // On release only a strictly stronger live request displaces the latch.
                        r_pc        <= (w_req_kind > r_pend_kind) ? w_req_addr : r_pend_addr;
                        r_redirect  <= 1'b1;
                        r_pend      <= 1'b0;
                        r_pend_kind <= K_NONE;
                        r_state     <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    assign bus.pc_o       = r_pc;
    assign bus.pc_plus_o  = w_pc_plus;
    assign bus.redirect_o = r_redirect;
    assign bus.pend_o     = r_pend;
endmodule

// File: tb/tb_pc_next_unit.sv
// Bench for pc_next_unit: a table of per-cycle stimulus with hand-derived
// expected PC/flags, queued as a scoreboard and compared after each edge,
// followed by hand-written asynchronous-reset sequences.
module tb_pc_next_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pc_next_if #(.W(32)) bus ();

    pc_next_unit #(
        .W(32), .RESET_PC(32'h0), .EXC_VEC(32'h80), .INC(4), .ALIGN(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        exc;
        logic        jmp;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic [31:0] e_pc;
        logic        e_rd;
        logic        e_pend;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        rd;
        logic        pend;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void v(input logic s, input logic e, input logic j,
                              input logic [31:0] jt, input logic b,
                              input logic [31:0] bt, input logic [31:0] pc,
                              input logic rd, input logic pd);
        vec_t t;
        t.stall = s; t.exc = e; t.jmp = j; t.jt = jt; t.br = b; t.bt = bt;
        t.e_pc = pc; t.e_rd = rd; t.e_pend = pd;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic e, input logic j,
                         input logic [31:0] jt, input logic b, input logic [31:0] bt);
        bus.stall_i = s; bus.exc_i = e; bus.jmp_i = j;
        bus.jmp_target_i = jt; bus.br_i = b; bus.br_target_i = bt;
    endtask

    initial begin
        exp_t x;
        drive(0, 0, 0, 0, 0, 0);

        //  stall exc jmp jt            br  bt            pc            rd pend
        v(0, 0, 0, 32'h0,        0, 32'h0,   32'h4,        0, 0); // sequential
        v(0, 0, 1, 32'hFFFFFFF8, 0, 32'h0,   32'hFFFFFFF8, 1, 0); // jump near top
        v(0, 0, 0, 32'h0,        0, 32'h0,   32'hFFFFFFFC, 0, 0);
        v(0, 0, 0, 32'h0,        0, 32'h0,   32'h00000000, 0, 0); // wrap
        v(0, 0, 0, 32'h0,        0, 32'h0,   32'h00000004, 0, 0);
        v(0, 0, 1, 32'h100,      0, 32'h0,   32'h100,      1, 0);
        v(0, 1, 1, 32'h200,      1, 32'h300, 32'h80,       1, 0); // all three: exc wins
        v(0, 0, 1, 32'h123,      0, 32'h0,   32'h120,      1, 0); // aligned
        v(0, 0, 0, 32'h0,        1, 32'h40,  32'h40,       1, 0);
        v(0, 0, 1, 32'h600,      1, 32'h700, 32'h600,      1, 0); // jmp beats br
        v(1, 0, 0, 32'h0,        1, 32'h44,  32'h600,      0, 1); // latch br in stall
        v(1, 0, 0, 32'h0,        0, 32'h0,   32'h600,      0, 1);
        v(1, 0, 0, 32'h0,        0, 32'h0,   32'h600,      0, 1);
        v(0, 0, 0, 32'h0,        0, 32'h0,   32'h44,       1, 0); // release
        v(1, 0, 0, 32'h0,        1, 32'h40,  32'h44,       0, 1);
        v(1, 0, 1, 32'h300,      0, 32'h0,   32'h44,       0, 1); // jmp overrides br
        v(0, 0, 0, 32'h0,        1, 32'h500, 32'h300,      1, 0); // weaker live br loses
        v(1, 0, 1, 32'h800,      0, 32'h0,   32'h300,      0, 1);
        v(1, 0, 0, 32'h0,        1, 32'h900, 32'h300,      0, 1); // lower kind ignored
        v(1, 0, 1, 32'hA00,      0, 32'h0,   32'h300,      0, 1); // equal kind: newest
        v(0, 0, 1, 32'hB00,      0, 32'h0,   32'hA00,      1, 0); // equal live loses
        v(1, 0, 0, 32'h0,        1, 32'h10,  32'hA00,      0, 1);
        v(0, 1, 0, 32'h0,        0, 32'h0,   32'h80,       1, 0); // stronger live wins
        v(1, 0, 0, 32'h0,        0, 32'h0,   32'h80,       0, 0); // plain stall
        v(0, 0, 0, 32'h0,        0, 32'h0,   32'h84,       0, 0);
        v(1, 1, 0, 32'h0,        0, 32'h0,   32'h84,       0, 1); // latch exc
        v(1, 0, 1, 32'h1000,     0, 32'h0,   32'h84,       0, 1); // lower ignored
        v(0, 0, 0, 32'h0,        0, 32'h0,   32'h80,       1, 0);

        // Reset state, checked while rst_n is still low.
        #3;
        chk("reset_pc", bus.pc_o, 32'h0);
        chk("reset_redirect", {31'b0, bus.redirect_o}, 32'h0);
        chk("reset_pend", {31'b0, bus.pend_o}, 32'h0);
        chk("reset_pc_plus", bus.pc_plus_o, 32'h4);
        #9 rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].exc, vecs[i].jmp, vecs[i].jt, vecs[i].br, vecs[i].bt);
            sb.push_back('{pc: vecs[i].e_pc, rd: vecs[i].e_rd, pend: vecs[i].e_pend});
            @(posedge clk);
            #1;
            x = sb.pop_front();
            chk($sformatf("v%0d_pc", i), bus.pc_o, x.pc);
            chk($sformatf("v%0d_redirect", i), {31'b0, bus.redirect_o}, {31'b0, x.rd});
            chk($sformatf("v%0d_pend", i), {31'b0, bus.pend_o}, {31'b0, x.pend});
            chk($sformatf("v%0d_pc_plus", i), bus.pc_plus_o, x.pc + 32'd4);
        end

        // Asynchronous reset while a redirect is pending discards the latch.
        drive(1, 0, 0, 0, 1, 32'h40);
        @(posedge clk); #1;
        chk("pend_before_reset", {31'b0, bus.pend_o}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pc", bus.pc_o, 32'h0);
        chk("async_rst_pend", {31'b0, bus.pend_o}, 32'h0);
        chk("async_rst_redirect", {31'b0, bus.redirect_o}, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_pc", bus.pc_o, 32'h4);
        chk("post_rst_redirect", {31'b0, bus.redirect_o}, 32'h0);
        chk("post_rst_pend", {31'b0, bus.pend_o}, 32'h0);

        // Asynchronous reset clears a live redirect flag.
        drive(0, 0, 1, 32'h123, 0, 0);
        @(posedge clk); #1;
        chk("jmp_align_pc", bus.pc_o, 32'h120);
        chk("jmp_align_redirect", {31'b0, bus.redirect_o}, 32'h1);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_clears_redirect", {31'b0, bus.redirect_o}, 32'h0);
        chk("rst_clears_pc", bus.pc_o, 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
